// File: rtl/uart_rx_deserializer.sv
// 8N1 serial receiver: synchronizes rxd, samples mid-bit using a latched clocks-per-bit divisor.
// Strobes valid/err SYNC_STAGES+1+(div>>1)+DATA_WIDTH*div+div cycles after the start edge; no backpressure.
module uart_rx_deserializer #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DIV_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [DIV_WIDTH-1:0]  uart_divide,
   output logic [DATA_WIDTH-1:0] uart_rx_data,
   output logic                  uart_rx_valid,
   output logic                  uart_rx_err,
   output logic                  active
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
   localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);
   localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sync;
   logic                    rxs;
   logic                    rxs_d;
   logic [DIV_WIDTH-1:0]    div_in;
   logic [DIV_WIDTH-1:0]    div_q;
   logic [DIV_WIDTH-1:0]    cnt;
   logic [IDX_W-1:0]        bit_idx;
   logic [DATA_WIDTH-1:0]   shreg;

   assign rxs    = sync[SYNC_STAGES-1];
   // Very small divisors would leave no room for a mid-bit sample.
   assign div_in = (uart_divide < MIN_DIV) ? MIN_DIV : uart_divide;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sync          <= '1;
         rxs_d         <= 1'b1;
         div_q         <= '0;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         uart_rx_data  <= '0;
         uart_rx_valid <= 1'b0;
         uart_rx_err   <= 1'b0;
         active        <= 1'b0;
      end else begin
         sync          <= {sync[SYNC_STAGES-2:0], rxd};
         rxs_d         <= rxs;
         uart_rx_valid <= 1'b0;
         uart_rx_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (rxs_d && !rxs) begin
                  state  <= START;
                  active <= 1'b1;
                  div_q  <= div_in;
                  cnt    <= (div_in >> 1) - ONE;
               end
            end

            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - ONE;
               end else if (!rxs) begin
                  state   <= DATA;
                  cnt     <= div_q - ONE;
                  bit_idx <= '0;
               end else begin
                  state  <= IDLE;
                  active <= 1'b0;
               end
            end

            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - ONE;
               end else begin
                  shreg[bit_idx] <= rxs;
                  cnt            <= div_q - ONE;
                  if (bit_idx == LAST_IDX) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_ONE;
                  end
               end
            end

            STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - ONE;
               end else if (rxs) begin
                  uart_rx_valid <= 1'b1;
                  uart_rx_data  <= shreg;
                  state         <= IDLE;
                  active        <= 1'b0;
               end else begin
                  // Stays in BRK so a held-low line reports only one error.
                  uart_rx_err <= 1'b1;
                  state       <= BRK;
               end
            end

            BRK: begin
               if (rxs) begin
                  state  <= IDLE;
                  active <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule
